counter_seq_ctrl: RTL and testbench

//  Run/pause/step sequencer for the board's 6-bit LED counter. Turns button

---
 rtl/counter_pkg.sv | 8 +
 rtl/tick_gen.sv | 19 +
 rtl/counter_seq_ctrl.sv | 78 +++++++
 tb/tb_counter_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default width for the LED counter sequencer
package counter_pkg;
  localparam int DEF_CNT_W = 6;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler raising tick once every DIV cycles while run is high
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] presc;
  assign tick = run && (presc == LAST);
  always_ff @(posedge clk) begin
    if (rst || clr) presc <= '0;
    else if (run) presc <= (presc == LAST) ? '0 : presc + 1'b1;
  end
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/pause/step sequencer producing count-enable ticks and restart requests
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_step,
  input  logic             mode_oneshot,
  input  logic [CNT_W-1:0] cnt,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [1:0]       state,
  output logic             busy
);
  logic [2:0] btn_q, evt;
  logic [1:0] nxt_state;
  logic       nxt_en, nxt_clr, presc_clr, tick;
  wire evt_stop  = evt[2];
  wire evt_start = evt[1];
  wire evt_step  = evt[0];
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .run (state == ST_RUN),
    .clr (presc_clr),
    .tick(tick)
  );
  always_comb begin
    nxt_state = state;
    nxt_en    = 1'b0;
    nxt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_state = evt_start ? ST_RUN : ST_IDLE;
        nxt_clr   = evt_start;
        nxt_en    = !evt_start && evt_step;
      end
      ST_RUN: begin
        nxt_state = evt_stop ? ST_PAUSE : (tick && mode_oneshot && &cnt) ? ST_DONE : ST_RUN;
        nxt_en    = !evt_stop && tick && !(mode_oneshot && &cnt);
      end
      ST_PAUSE: begin
        nxt_state = evt_stop ? ST_IDLE : evt_start ? ST_RUN : ST_PAUSE;
        nxt_clr   = evt_stop;
        nxt_en    = !evt_stop && !evt_start && evt_step;
      end
      ST_DONE: begin
        nxt_state = evt_stop ? ST_IDLE : evt_start ? ST_RUN : ST_DONE;
        nxt_clr   = !evt_stop && evt_start;
      end
    endcase
  end
  // Only the RUN<->PAUSE transitions keep the prescaler; every other state change restarts it
  assign presc_clr = (nxt_state != state) && (nxt_state != ST_PAUSE) &&
                     !(state == ST_PAUSE && nxt_state == ST_RUN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      btn_q   <= '0;
      evt     <= '0;
    end else begin
      btn_q   <= {btn_stop, btn_start, btn_step};
      evt     <= {btn_stop, btn_start, btn_step} & ~btn_q;
      state   <= nxt_state;
      cnt_en  <= nxt_en;
      cnt_clr <= nxt_clr;
      busy    <= (nxt_state == ST_RUN);
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed scenarios for the sequencer with a reloadable counter model in the loop
module tb_counter_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_step = 1'b0, mode_oneshot = 1'b0;
  logic [5:0] cnt_m = 6'd0;
  logic       cnt_en, cnt_clr, busy;
  logic [1:0] state;
  int         errors = 0, checks = 0, pulses = 0;

  counter_seq_ctrl #(.CNT_W(6), .TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_stop    (btn_stop),
    .btn_step    (btn_step),
    .mode_oneshot(mode_oneshot),
    .cnt         (cnt_m),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .state       (state),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr) cnt_m <= 6'd1;
    else if (cnt_en) cnt_m <= cnt_m + 6'd1;
    if (cnt_en) pulses <= pulses + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    rst = 1'b0;
    checks++;
    if (state !== 2'b00 || cnt_en !== 1'b0 || cnt_clr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%b en=%b clr=%b busy=%b, want 00 0 0 0", state, cnt_en, cnt_clr, busy);
    end
  endtask

  task automatic test_run();
    logic exp;
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
    checks++;
    if (cnt_clr !== 1'b1 || state !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_start: clr=%b state=%b busy=%b, want 1 01 1", cnt_clr, state, busy);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = (i % 4 == 0);
      checks++;
      if (cnt_en !== exp) begin
        errors++;
        $display("FAIL run_tick[%0d]: cnt_en=%b, want %b", i, cnt_en, exp);
      end
    end
    checks++;
    if (cnt_m !== 6'd3) begin
      errors++;
      $display("FAIL run_count: cnt=%0d, want 3", cnt_m);
    end
  endtask

  task automatic test_pause_resume();
    int p0;
    btn_stop = 1'b1; cyc(); btn_stop = 1'b0; p0 = pulses; cyc();
    checks++;
    if (state !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: state=%b busy=%b, want 10 0", state, busy);
    end
    repeat (10) cyc();
    checks++;
    if (pulses != p0 || cnt_m !== 6'd4) begin
      errors++;
      $display("FAIL pause_hold: pulses=%0d cnt=%0d, want 0 4", pulses - p0, cnt_m);
    end
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
    checks++;
    if (state !== 2'b01 || cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin
      errors++;
      $display("FAIL resume: state=%b en=%b clr=%b, want 01 0 0", state, cnt_en, cnt_clr);
    end
    cyc();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL resume_wait: cnt_en=%b, want 0", cnt_en);
    end
    cyc();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick: cnt_en=%b, want 1", cnt_en);
    end
    btn_stop = 1'b1; cyc(); btn_stop = 1'b0; cyc();
    checks++;
    if (state !== 2'b10 || cnt_m !== 6'd5) begin
      errors++;
      $display("FAIL repause: state=%b cnt=%0d, want 10 5", state, cnt_m);
    end
  endtask

  task automatic test_step();
    int p0;
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      btn_step = 1'b1; cyc(); btn_step = 1'b0;
      repeat (3) cyc();
    end
    checks++;
    if (pulses - p0 != 3 || state !== 2'b10 || cnt_m !== 6'd8) begin
      errors++;
      $display("FAIL step_edges: pulses=%0d state=%b cnt=%0d, want 3 10 8", pulses - p0, state, cnt_m);
    end
    p0 = pulses;
    btn_step = 1'b1; repeat (20) cyc(); btn_step = 1'b0;
    repeat (3) cyc();
    checks++;
    if (pulses - p0 != 1 || cnt_m !== 6'd9) begin
      errors++;
      $display("FAIL step_held: pulses=%0d cnt=%0d, want 1 9", pulses - p0, cnt_m);
    end
  endtask

  task automatic test_oneshot();
    int p0, n;
    btn_stop = 1'b1; cyc(); btn_stop = 1'b0; cyc();
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b1) begin
      errors++;
      $display("FAIL pause_abort: state=%b clr=%b, want 00 1", state, cnt_clr);
    end
    cyc();
    mode_oneshot = 1'b1;
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
    checks++;
    if (cnt_clr !== 1'b1 || state !== 2'b01 || cnt_m !== 6'd1) begin
      errors++;
      $display("FAIL oneshot_start: clr=%b state=%b cnt=%0d, want 1 01 1", cnt_clr, state, cnt_m);
    end
    p0 = pulses;
    n = 0;
    for (int i = 1; i <= 300 && n == 0; i++) begin
      cyc();
      if (state === 2'b11) n = i;
    end
    checks++;
    if (n != 252) begin
      errors++;
      $display("FAIL oneshot_done_time: reached DONE after %0d cycles, want 252", n);
    end
    checks++;
    if (pulses - p0 != 62 || cnt_m !== 6'd63 || busy !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_done: pulses=%0d cnt=%0d busy=%b en=%b, want 62 63 0 0", pulses - p0, cnt_m, busy, cnt_en);
    end
    p0 = pulses;
    btn_step = 1'b1; cyc(); btn_step = 1'b0;
    repeat (4) cyc();
    checks++;
    if (pulses != p0 || state !== 2'b11 || cnt_m !== 6'd63) begin
      errors++;
      $display("FAIL done_step: pulses=%0d state=%b cnt=%0d, want 0 11 63", pulses - p0, state, cnt_m);
    end
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
    checks++;
    if (cnt_clr !== 1'b1 || state !== 2'b01) begin
      errors++;
      $display("FAIL done_restart: clr=%b state=%b, want 1 01", cnt_clr, state);
    end
    cyc();
    checks++;
    if (cnt_m !== 6'd1) begin
      errors++;
      $display("FAIL done_reload: cnt=%0d, want 1", cnt_m);
    end
  endtask

  task automatic test_wrap();
    mode_oneshot = 1'b0;
    repeat (251) cyc();
    checks++;
    if (cnt_en !== 1'b1 || cnt_m !== 6'd63) begin
      errors++;
      $display("FAIL wrap_pulse: en=%b cnt=%0d, want 1 63", cnt_en, cnt_m);
    end
    cyc();
    checks++;
    if (cnt_m !== 6'd0 || state !== 2'b01) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%0d state=%b, want 0 01", cnt_m, state);
    end
    repeat (4) cyc();
    checks++;
    if (cnt_m !== 6'd1 || state !== 2'b01) begin
      errors++;
      $display("FAIL wrap_one: cnt=%0d state=%b, want 1 01", cnt_m, state);
    end
  endtask

  task automatic test_abort_reset();
    btn_stop = 1'b1; cyc(); btn_stop = 1'b0; cyc();
    btn_start = 1'b1; btn_stop = 1'b1; cyc();
    btn_start = 1'b0; btn_stop = 1'b0; cyc();
    checks++;
    if (state !== 2'b00 || cnt_clr !== 1'b1 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_same: state=%b clr=%b en=%b, want 00 1 0", state, cnt_clr, cnt_en);
    end
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
    repeat (3) cyc();
    rst = 1'b1; cyc();
    checks++;
    if (state !== 2'b00 || cnt_en !== 1'b0 || cnt_clr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: state=%b en=%b clr=%b busy=%b, want 00 0 0 0", state, cnt_en, cnt_clr, busy);
    end
    btn_start = 1'b1; cyc(); rst = 1'b0; cyc();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL held_btn_latency: state=%b, want 00", state);
    end
    cyc();
    checks++;
    if (state !== 2'b01 || cnt_clr !== 1'b1) begin
      errors++;
      $display("FAIL held_btn_event: state=%b clr=%b, want 01 1", state, cnt_clr);
    end
    btn_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause_resume();
    test_step();
    test_oneshot();
    test_wrap();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
